// File: rtl/vrf_pkg.sv
// Shared definitions for the vector-register-file writeback arbiter.
//   NUM_VREGS     architectural vector register count
//   VLMUL_*       register-group size codes (1/2/4/8 registers)
//   state_t       arbiter FSM states
//   lmul_beats()  beats needed for a group code (reserved codes count as one beat)
package vrf_pkg;

  localparam int NUM_VREGS = 32;

  localparam logic [2:0] VLMUL_M1 = 3'b000;
  localparam logic [2:0] VLMUL_M2 = 3'b001;
  localparam logic [2:0] VLMUL_M4 = 3'b010;
  localparam logic [2:0] VLMUL_M8 = 3'b011;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Reserved/fractional codes (bit 2 set) are drained as a single beat.
  function automatic logic [3:0] lmul_beats(input logic [2:0] vlmul);
    if (vlmul[2]) return 4'd1;
    return 4'd1 << vlmul[1:0];
  endfunction

endpackage

// File: rtl/vrf_wb_arbiter_rr_arbiter.sv
// Round-robin grant picker.
//   req    in   N    request vector
//   ptr    in   PW   highest-priority index
//   grant  out  N    one-hot grant: first set req at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;

  // Outer loop walks priority distance from ptr; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int d = 0; d < N; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + d) % N))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Writeback port arbiter for the vector register file.
// Round-robin among NUM_REQ producers; a grant is held for a full LMUL
// register group written one register per beat. Outputs are registered.
//   clk, rst_n               clock, async active-low reset
//   req_valid/req_ready      per-requester beat handshake (ready is combinational)
//   req_vd/req_vlmul         group base/size, sampled on beat 0 only
//   req_data                 per-requester beat data
//   wb_load/wb_sel/wb_data   registered register write, one beat per cycle
//   wb_vlmul                 constant 0: each beat writes one register
//   err/err_src              malformed-group pulse and sticky requester index
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; round-robin winner's beat 0 is accepted directly
// ST_BURST | grant locked to owner until the group's last beat is accepted
module vrf_wb_arbiter
  import vrf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*6-1:0]        req_vd,
  input  logic [NUM_REQ*3-1:0]        req_vlmul,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        wb_load,
  output logic [5:0]                  wb_sel,
  output logic [2:0]                  wb_vlmul,
  output logic [DATA_W-1:0]           wb_data,
  output logic                        err,
  output logic [2:0]                  err_src
);

  localparam int PW = $clog2(NUM_REQ);

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic [3:0]          beat_cnt;
  logic [3:0]          nbeats;
  logic [5:0]          base;
  logic                bad_grp;

  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  owner_mask;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       sel_idx;
  logic [PW-1:0]       ptr_next;
  logic [5:0]          cur_vd;
  logic [2:0]          cur_vlmul;
  logic [DATA_W-1:0]   cur_data;
  logic [3:0]          cur_beats;
  logic                cur_bad;
  logic                accept;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign wb_vlmul = VLMUL_M1;

  always_comb begin
    win_idx    = '0;
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PW'(i);
      if (owner == PW'(i)) owner_mask[i] = 1'b1;
    end

    // Ready is forced low while in reset so an abandoned burst cannot
    // see a beat accepted.
    if (!rst_n)                req_ready = '0;
    else if (state == ST_IDLE) req_ready = grant;
    else                       req_ready = req_valid & owner_mask;
    accept = |req_ready;

    sel_idx   = (state == ST_IDLE) ? win_idx : owner;
    cur_vd    = '0;
    cur_vlmul = '0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PW'(i)) begin
        cur_vd    = req_vd[i*6 +: 6];
        cur_vlmul = req_vlmul[i*3 +: 3];
        cur_data  = req_data[i*DATA_W +: DATA_W];
      end
    end

    cur_beats = lmul_beats(cur_vlmul);
    // Alignment to the group size also guarantees the group stays below v32.
    cur_bad   = cur_vlmul[2] || (cur_vd >= 6'(NUM_VREGS)) ||
                ((cur_vd & 6'(cur_beats - 4'd1)) != 6'd0);

    ptr_next  = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      nbeats   <= '0;
      base     <= '0;
      bad_grp  <= 1'b0;
      wb_load  <= 1'b0;
      wb_sel   <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
      err_src  <= '0;
    end else begin
      wb_load <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner   <= win_idx;
            base    <= cur_vd;
            nbeats  <= cur_beats;
            bad_grp <= cur_bad;
            wb_load <= !cur_bad;
            if (!cur_bad) begin
              wb_sel  <= cur_vd;
              wb_data <= cur_data;
            end else begin
              err     <= 1'b1;
              err_src <= 3'(win_idx);
            end
            if (cur_beats == 4'd1) begin
              rr_ptr <= ptr_next;
            end else begin
              state    <= ST_BURST;
              beat_cnt <= 4'd1;
            end
          end
        end
        ST_BURST: begin
          if (accept) begin
            wb_load <= !bad_grp;
            if (!bad_grp) begin
              wb_sel  <= base + {2'b00, beat_cnt};
              wb_data <= cur_data;
            end
            if (beat_cnt == nbeats - 4'd1) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
              rr_ptr   <= ptr_next;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
